pipe_seq_ctrl: RTL
==================

Name: pipe_seq_ctrl

Overview:
- Sequencing controller for the 16-bit three-stage (IF/ID/EX) datapath.
- Drives the PC, the IF/ID and ID/EX pipeline-register enables and flushes, and the EX-stage write strobes to the register file and to the output register.
- Resolves stalls (multi-cycle EX, load-use hazard), taken branches and HALT.
- Keeps saturating retire and stall counters for debug.

Parameters:
CNT_W, 16, width of instr_cnt and stall_cnt

Ports:
clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
run  in  1  enable execution; 0 freezes pipeline
halt_id  in  1  ID stage holds HALT opcode
hazard_id  in  1  ID operand depends on EX result not yet written
ex_busy  in  1  EX performing multi-cycle op, not finished
branch_ex  in  1  EX resolved a taken branch this cycle
ex_wr  in  1  EX instruction writes register file
ex_out  in  1  EX instruction writes output register
pc_en  out  1  PC/IF advance (loads target on branch)
ifid_en  out  1  IF/ID register load
idex_en  out  1  ID/EX register load
ifid_flush  out  1  IF/ID load bubble
idex_flush  out  1  ID/EX load bubble
rf_we  out  1  register-file write strobe
out_we  out  1  output-register write strobe
running  out  1  state==RUN
halted  out  1  state==HALTED
instr_cnt  out  CNT_W  retired instructions, saturating
stall_cnt  out  CNT_W  stall cycles, saturating

Behaviour:
- One clock (clk); reset is asynchronous, active-low (nReset).
- Reset: state=IDLE, v_id=v_ex=0 (internal stage-valid bits), counters 0. All outputs 0 while nReset low and in IDLE.
- Strobe/enable outputs are combinational from state, valid bits and inputs (0-cycle latency).
- State, valid bits and counters are registered.
- IDLE: all enables 0.
  - run=1 -> RUN next cycle, v_id=v_ex=0.
- RUN, run=0: all enables/strobes 0; state, valid bits and counters held.
- RUN, run=1, evaluated in priority order:
  1. ex_busy & v_ex: all enables, flushes and strobes 0; no retire; stall_cnt+1.
  2. branch_ex & v_ex: pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=idex_en=0. EX retires. Next v_id=0, v_ex=0.
  3. hazard_id & v_id: pc_en=0, ifid_en=0, idex_flush=1. EX retires. Next v_ex=0, v_id held; stall_cnt+1.
  4. halt_id & v_id: pc_en=0, ifid_en=0, idex_flush=1. EX retires. Next state=HALTED, v_id=v_ex=0.
  5. else: pc_en=ifid_en=idex_en=1. EX retires. Next v_id=1, v_ex=v_id.
- Retire (cases 2-5 only, requires v_ex=1): rf_we=ex_wr, out_we=ex_out, instr_cnt+1.
  - No retire: rf_we=out_we=0.
  - Inputs ex_wr/ex_out/branch_ex/ex_busy are ignored when v_ex=0.
  - halt_id/hazard_id are ignored when v_id=0.
- Flush and enable for the same register are never both 1; flush takes effect as the register load.
- HALTED: all enables 0, halted=1.
  - run=0 -> IDLE next cycle.
  - run=1 -> remain HALTED.
- Counters saturate at 2^CNT_W-1 (no wrap).
- Fill timing: run rises while IDLE at cycle 0 -> RUN at cycle 1 (v_id=0) -> v_id=1 at cycle 2 -> v_ex=1 at cycle 3, which is the first possible retire.
- Simultaneous events:
  - branch_ex with halt_id: branch wins, HALT is flushed, state stays RUN.
  - ex_busy with branch_ex: busy wins and the branch is taken on the first non-busy cycle.
- Reset mid-operation: immediate return to IDLE, outputs 0, counters cleared; no partial strobe may survive reset assertion.

Test Plan:
1. Reset; run=1 from cycle 0, ex_wr=1 held -> pc_en=1 from cycle 1, first rf_we=1 at cycle 3, instr_cnt=1 after cycle-3 edge, rf_we=1 every following cycle.
2. Steady RUN, hazard_id=1 for one cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1. Next cycle rf_we=0 (bubble). stall_cnt=1, instr_cnt misses one increment.
3. Steady RUN, branch_ex=1 with ex_out=1 -> same cycle out_we=1, pc_en=1, ifid_flush=idex_flush=1. Next two cycles rf_we=out_we=0, retire resumes on the third.
4. ex_busy=1 for 3 cycles with v_ex=1 -> all enables/strobes 0 for 3 cycles, stall_cnt+=3, instr_cnt unchanged. Retire happens on the 4th cycle.
5. halt_id=1 with branch_ex=1 -> state stays RUN, halted=0. Later halt_id alone -> halted=1 next cycle. run=0 -> IDLE the cycle after.
6. Preload counters near max (CNT_W=4 build, 15 retires) -> instr_cnt stays 15. Assert nReset mid-RUN -> all outputs 0 immediately, counters 0, state IDLE.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl
//   Sequencing controller for the 16-bit three-stage (IF/ID/EX) datapath.
//   Generates the PC advance, the IF/ID and ID/EX load enables and flushes,
//   and the EX-stage register-file and output-register write strobes.
//   It resolves multi-cycle EX stalls, load-use hazards, taken branches and
//   HALT, and keeps saturating retire and stall counters for debug.
//
// Ports
//   clk, nReset            clock (rising edge), async active-low reset
//   run                    enable execution; 0 freezes the pipeline
//   halt_id, hazard_id     ID-stage HALT opcode / operand hazard on EX result
//   ex_busy, branch_ex     EX multi-cycle in progress / EX taken branch
//   ex_wr, ex_out          EX instruction writes register file / output reg
//   pc_en, ifid_en, idex_en, ifid_flush, idex_flush
//                          pipeline advance, load enables and bubble loads
//   rf_we, out_we          EX retire write strobes
//   running, halted        state decode
//   instr_cnt, stall_cnt   saturating retired-instruction / stall-cycle counts
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | reset / stopped; all enables off, waits for run
// RUN    | pipeline active; v_id / v_ex track which stages hold work
// HALTED | HALT reached ID; holds until run drops, then back to IDLE

module pipe_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             run,
  input  logic             halt_id,
  input  logic             hazard_id,
  input  logic             ex_busy,
  input  logic             branch_ex,
  input  logic             ex_wr,
  input  logic             ex_out,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             rf_we,
  output logic             out_we,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;
  logic   v_id, v_ex, v_id_nxt, v_ex_nxt;
  logic   retire, stall;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      v_id      <= 1'b0;
      v_ex      <= 1'b0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      v_id  <= v_id_nxt;
      v_ex  <= v_ex_nxt;
      if (retire && (instr_cnt != CNT_MAX))
        instr_cnt <= instr_cnt + CNT_ONE;
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt  = state;
    v_id_nxt   = v_id;
    v_ex_nxt   = v_ex;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    retire     = 1'b0;
    stall      = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = RUN;
          v_id_nxt  = 1'b0;
          v_ex_nxt  = 1'b0;
        end
      end

      RUN: begin
        // run low freezes everything, including the valid bits.
        if (run) begin
          if (ex_busy && v_ex) begin
            // Busy outranks a pending branch: the branch is taken on the
            // first cycle EX is no longer busy.
            stall = 1'b1;
          end else if (branch_ex && v_ex) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            retire     = 1'b1;
            v_id_nxt   = 1'b0;
            v_ex_nxt   = 1'b0;
          end else if (hazard_id && v_id) begin
            // Hold IF and ID, push a bubble into EX; the EX op still retires.
            idex_flush = 1'b1;
            retire     = v_ex;
            v_ex_nxt   = 1'b0;
            stall      = 1'b1;
          end else if (halt_id && v_id) begin
            idex_flush = 1'b1;
            retire     = v_ex;
            state_nxt  = HALTED;
            v_id_nxt   = 1'b0;
            v_ex_nxt   = 1'b0;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            retire   = v_ex;
            v_id_nxt = 1'b1;
            v_ex_nxt = v_id;
          end
        end
      end

      HALTED: begin
        if (!run)
          state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        v_id_nxt  = 1'b0;
        v_ex_nxt  = 1'b0;
      end
    endcase
  end

  assign rf_we   = retire & ex_wr;
  assign out_we  = retire & ex_out;
  assign running = (state == RUN);
  assign halted  = (state == HALTED);

endmodule
